// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM of the multi-cycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables and mux selects. Supports LW, SW, R-type ALU,
// I-type ALU, BEQ and JAL; memory accesses stall on i_memReady.
module multicycle_main_fsm (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic       o_regWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluControl,
    output logic       o_illegal,
    output logic       o_retire
);

    // Opcode encoding (instr[6:0])
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALU op encoding {funct7b5, funct3}
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Result mux selects
    localparam logic [1:0] RES_ALU     = 2'b00;
    localparam logic [1:0] RES_DMEM    = 2'b01;
    localparam logic [1:0] RES_PCPLUS4 = 2'b10;

    // ALU A-input selects
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OTHER = 2'b01;
    localparam logic [1:0] A_RD1   = 2'b10;

    // ALU B-input selects
    localparam logic [1:0] B_RD2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       w_legal_r;
    logic       w_legal_i;

    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_illegal;
    logic       w_retire;

    // Legal R-type / I-type ALU encodings (only meaningful once IR is stable)
    always_comb begin
        w_legal_r = 1'b0;
        w_legal_i = 1'b0;
        case ({i_funct7b5, i_funct3})
            4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0110, 4'b0111: w_legal_r = 1'b1;
            default:                                               w_legal_r = 1'b0;
        endcase
        case (i_funct3)
            3'b000, 3'b010, 3'b100, 3'b110, 3'b111: w_legal_i = 1'b1;
            default:                                w_legal_i = 1'b0;
        endcase
    end

    // State register; reset aborts any in-flight instruction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_state_nxt;
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_nxt = i_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_R:         w_state_nxt = w_legal_r ? S_EXECR : S_FETCH;
                    OP_I:         w_state_nxt = w_legal_i ? S_EXECI : S_FETCH;
                    OP_B:         w_state_nxt = (i_funct3 == 3'b000) ? S_BEQ : S_FETCH;
                    OP_JAL:       w_state_nxt = S_JAL;
                    default:      w_state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_nxt = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_state_nxt = i_memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_state_nxt = S_FETCH;
            S_MEMWRITE: w_state_nxt = i_memReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_state_nxt = S_ALUWB;
            S_EXECI:    w_state_nxt = S_ALUWB;
            S_ALUWB:    w_state_nxt = S_FETCH;
            S_BEQ:      w_state_nxt = S_FETCH;
            S_JAL:      w_state_nxt = S_ALUWB;
            default:    w_state_nxt = S_FETCH;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        w_pc_write   = 1'b0;
        o_adrSrc     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        o_resultSrc  = RES_ALU;
        o_aluSrcA    = A_PC;
        o_aluSrcB    = B_RD2;
        o_aluControl = ALU_ADD;
        w_illegal    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_aluSrcB   = B_FOUR;
                o_resultSrc = RES_PCPLUS4;
                w_ir_write  = i_memReady;
                w_pc_write  = i_memReady;
            end
            S_DECODE: begin
                o_aluSrcA = A_OTHER;
                o_aluSrcB = B_IMM;
                case (i_op)
                    OP_LW, OP_SW, OP_JAL: w_illegal = 1'b0;
                    OP_R:                 w_illegal = !w_legal_r;
                    OP_I:                 w_illegal = !w_legal_i;
                    OP_B:                 w_illegal = (i_funct3 != 3'b000);
                    default:              w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = A_RD1;
                o_aluSrcB = B_IMM;
            end
            S_MEMREAD: begin
                o_adrSrc = 1'b1;
            end
            S_MEMWB: begin
                o_resultSrc = RES_DMEM;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                o_adrSrc    = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = i_memReady;
            end
            S_EXECR: begin
                o_aluSrcA    = A_RD1;
                o_aluSrcB    = B_RD2;
                o_aluControl = {i_funct7b5, i_funct3};
            end
            S_EXECI: begin
                o_aluSrcA    = A_RD1;
                o_aluSrcB    = B_IMM;
                o_aluControl = {1'b0, i_funct3};
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ: begin
                o_aluSrcA    = A_RD1;
                o_aluSrcB    = B_RD2;
                o_aluControl = ALU_SUB;
                w_pc_write   = i_zero;
                w_retire     = 1'b1;
            end
            S_JAL: begin
                o_aluSrcA  = A_OTHER;
                o_aluSrcB  = B_FOUR;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables and pulses are forced low for as long as reset is held
    assign o_pcWrite  = w_pc_write  & i_rst_n;
    assign o_memWrite = w_mem_write & i_rst_n;
    assign o_irWrite  = w_ir_write  & i_rst_n;
    assign o_regWrite = w_reg_write & i_rst_n;
    assign o_illegal  = w_illegal   & i_rst_n;
    assign o_retire   = w_retire    & i_rst_n;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm. A per-instruction model turns
// an instruction word plus stall pattern into the expected per-cycle output
// trace, which is then replayed against the DUT cycle by cycle.
module tb_multicycle_main_fsm;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [6:0] i_op = '0;
    logic [2:0] i_funct3 = '0;
    logic       i_funct7b5 = 1'b0;
    logic       i_zero = 1'b0;
    logic       i_memReady = 1'b0;
    logic       o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite;
    logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB;
    logic [3:0] o_aluControl;
    logic       o_illegal, o_retire;

    int nvec  = 0;
    int nfail = 0;

    multicycle_main_fsm dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_funct3(i_funct3),
        .i_funct7b5(i_funct7b5), .i_zero(i_zero), .i_memReady(i_memReady),
        .o_pcWrite(o_pcWrite), .o_adrSrc(o_adrSrc), .o_memWrite(o_memWrite),
        .o_irWrite(o_irWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
        .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluControl(o_aluControl),
        .o_illegal(o_illegal), .o_retire(o_retire)
    );

    always #5 i_clk = ~i_clk;

    // Packed view: {pc, adr, mw, ir, rw, rs[1:0], a[1:0], b[1:0], ctl[3:0], ill, ret}
    function automatic logic [16:0] pk(input logic pc, adr, mw, ir, rw,
                                       input logic [1:0] rs, a, b,
                                       input logic [3:0] ctl, input logic ill, ret);
        return {pc, adr, mw, ir, rw, rs, a, b, ctl, ill, ret};
    endfunction

    function automatic logic [16:0] obs();
        return {o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_regWrite, o_resultSrc,
                o_aluSrcA, o_aluSrcB, o_aluControl, o_illegal, o_retire};
    endfunction

    // Outputs while reset is asserted: no enables, FETCH-style selects
    localparam logic [16:0] RST_EXP = 17'b0_0_0_0_0_10_00_10_0000_0_0;

    // Expected trace: per cycle the driven ready/zero, whether IR is valid, and outputs
    logic [16:0] q_exp[$];
    bit          q_rdy[$];
    bit          q_zero[$];
    bit          q_dec[$];

    task automatic push(input bit rdy, input bit zr, input bit dec, input logic [16:0] e);
        q_rdy.push_back(rdy);
        q_zero.push_back(zr);
        q_dec.push_back(dec);
        q_exp.push_back(e);
    endtask

    // Build the expected trace for one instruction, then replay up to 'ncyc'
    // cycles of it (ncyc < 0 means the whole instruction).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input bit zr, input int ncyc, input string nm);
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        bit         ill;
        int         n;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[30];
        q_exp.delete(); q_rdy.delete(); q_zero.delete(); q_dec.delete();

        // fetch: stall cycles, then the ready cycle latches IR and PC+4
        for (int k = 0; k < fw; k++)
            push(1'b0, 1'($urandom_range(0, 1)), 1'b0, pk(0,0,0,0,0,2'b10,2'b00,2'b10,4'h0,0,0));
        push(1'b1, 1'($urandom_range(0, 1)), 1'b0, pk(1,0,0,1,0,2'b10,2'b00,2'b10,4'h0,0,0));

        case (op)
            7'h03, 7'h23, 7'h6f: ill = 1'b0;
            7'h33:   ill = !({f7, f3} inside {4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0110, 4'b0111});
            7'h13:   ill = !(f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
            7'h63:   ill = (f3 != 3'b000);
            default: ill = 1'b1;
        endcase
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
             pk(0,0,0,0,0,2'b00,2'b01,2'b01,4'h0,ill,0));

        if (!ill) begin
            case (op)
                7'h03: begin
                    push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'h0,0,0));
                    for (int k = 0; k < mw; k++)
                        push(1'b0, 1'($urandom_range(0,1)), 1'b1, pk(0,1,0,0,0,2'b00,2'b00,2'b00,4'h0,0,0));
                    push(1'b1, 1'($urandom_range(0,1)), 1'b1, pk(0,1,0,0,0,2'b00,2'b00,2'b00,4'h0,0,0));
                    push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,1,2'b01,2'b00,2'b00,4'h0,0,1));
                end
                7'h23: begin
                    push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'h0,0,0));
                    for (int k = 0; k < mw; k++)
                        push(1'b0, 1'($urandom_range(0,1)), 1'b1, pk(0,1,1,0,0,2'b00,2'b00,2'b00,4'h0,0,0));
                    push(1'b1, 1'($urandom_range(0,1)), 1'b1, pk(0,1,1,0,0,2'b00,2'b00,2'b00,4'h0,0,1));
                end
                7'h33, 7'h13, 7'h6f: begin
                    if (op == 7'h33)
                        push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,0,2'b00,2'b10,2'b00,{f7,f3},0,0));
                    else if (op == 7'h13)
                        push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,0,2'b00,2'b10,2'b01,{1'b0,f3},0,0));
                    else
                        push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(1,0,0,0,0,2'b00,2'b01,2'b10,4'h0,0,0));
                    push(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1, pk(0,0,0,0,1,2'b00,2'b00,2'b00,4'h0,0,1));
                end
                default: // BEQ
                    push(1'($urandom_range(0,1)), zr, 1'b1, pk(zr,0,0,0,0,2'b00,2'b10,2'b00,4'b1000,0,1));
            endcase
        end

        n = (ncyc < 0) ? q_exp.size() : ncyc;
        for (int c = 0; c < n; c++) begin
            i_memReady = q_rdy[c];
            i_zero     = q_zero[c];
            if (q_dec[c]) begin
                i_op = op; i_funct3 = f3; i_funct7b5 = f7;
            end else begin
                // IR not yet loaded: instruction fields are garbage and must not matter
                i_op = 7'($urandom); i_funct3 = 3'($urandom); i_funct7b5 = 1'($urandom);
            end
            #1;
            nvec++;
            if (obs() !== q_exp[c]) begin
                nfail++;
                $display("FAIL %s ins=%h cycle %0d: got %b want %b", nm, ins, c, obs(), q_exp[c]);
            end
            if (o_illegal && o_retire) begin
                nfail++;
                $display("FAIL %s ins=%h cycle %0d: illegal and retire together", nm, ins, c);
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_memReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            #1;
            nvec++;
            if (obs() !== RST_EXP) begin
                nfail++;
                $display("FAIL reset_hold cycle %0d: got %b want %b", k, obs(), RST_EXP);
            end
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_lw();
        run_instr(32'hFFC4A303, 0, 0, 1'b0, -1, "lw");
    endtask

    task automatic test_rtype();
        run_instr(32'h00628233, 0, 0, 1'b0, -1, "add");
        run_instr(32'h40628233, 0, 0, 1'b0, -1, "sub");
    endtask

    task automatic test_beq();
        run_instr(32'h00420463, 0, 0, 1'b1, -1, "beq_taken");
        run_instr(32'h00420463, 0, 0, 1'b0, -1, "beq_not_taken");
    endtask

    task automatic test_sw_stall();
        run_instr(32'h0064A223, 3, 3, 1'b0, -1, "sw_stall");
    endtask

    task automatic test_illegal_lui();
        run_instr(32'h00001337, 0, 0, 1'b0, -1, "lui_illegal");
    endtask

    task automatic test_reset_mid_memread();
        // fetch, decode, memadr, one memread stall cycle
        run_instr(32'hFFC4A303, 0, 3, 1'b0, 4, "lw_partial");
        i_memReady = 1'b1;
        i_rst_n = 1'b0;
        #1;
        nvec++;
        if (obs() !== RST_EXP) begin
            nfail++;
            $display("FAIL reset_mid_memread: got %b want %b", obs(), RST_EXP);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        nvec++;
        if (obs() !== RST_EXP) begin
            nfail++;
            $display("FAIL reset_mid_memread_hold: got %b want %b", obs(), RST_EXP);
        end
        i_rst_n = 1'b1;
        // must resume cleanly from FETCH
        run_instr(32'h00628233, 0, 0, 1'b0, -1, "add_after_reset");
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [6:0]  ops[7];
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h00};
        for (int t = 0; t < 200; t++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 6)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_sw_stall();
        test_illegal_lui();
        test_reset_mid_memread();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
